key_iv_loader: RTL and testbench

KEY_IV_LOADER -- requirements
Module: key_iv_loader

---
 rtl/key_iv_loader.sv | 101 ++++++++++
 tb/tb_key_iv_loader.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_iv_loader.sv
// Key/IV frame loader: assembles a 28-byte frame into a shadow
// register and commits IV and key to the cipher in one cycle.
module key_iv_loader #(
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [7:0]   din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic [188:0] key_o,
  output logic [31:0]  iv_o,
  output logic         kiv_valid,
  input  logic         kiv_ack,
  output logic         err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;
  localparam logic [1:0] ERR    = 2'd3;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [1:0]   state;
  logic [4:0]   cnt;
  logic [15:0]  idle;
  logic [223:0] shadow;
  logic         accept;
  logic         pad_bad;
  logic         last;
  logic         tmo;

  assign din_ready = (state == LOAD);
  assign accept    = din_ready & din_valid;
  assign pad_bad   = (cnt == 5'd4) && (din[7:5] != 3'b000);
  assign last      = (cnt == 5'd27);
  assign tmo       = (idle == TMO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idle      <= '0;
      shadow    <= '0;
      key_o     <= '0;
      iv_o      <= '0;
      kiv_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= LOAD;
            cnt    <= '0;
            idle   <= '0;
            err    <= 1'b0;
            shadow <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            shadow <= {shadow[215:0], din};
            idle   <= '0;
            if (pad_bad) begin
              state <= ERR;
              err   <= 1'b1;
            end else if (last) begin
              state <= COMMIT;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end else if (tmo) begin
            state <= ERR;
            err   <= 1'b1;
          end else begin
            idle <= idle + 16'd1;
          end
        end
        COMMIT: begin
          iv_o  <= shadow[223:192];
          key_o <= shadow[188:0];
          state <= IDLE;
        end
        ERR: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // a fresh commit outranks a coincident acknowledge
      if (state == COMMIT) begin
        kiv_valid <= 1'b1;
      end else if (kiv_ack) begin
        kiv_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_iv_loader.sv
// Self-checking bench for key_iv_loader with a commit scoreboard.
// Runs with TIMEOUT = 4 so the idle-abort path is exercised.
module tb_key_iv_loader;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [7:0]   din;
  logic         din_valid;
  logic         din_ready;
  logic [188:0] key_o;
  logic [31:0]  iv_o;
  logic         kiv_valid;
  logic         kiv_ack;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [188:0] key;
    logic [31:0]  iv;
  } pair_t;

  typedef logic [7:0] frame_t [28];

  pair_t sb[$];

  always #5 clk = ~clk;

  key_iv_loader #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .key_o     (key_o),
    .iv_o      (iv_o),
    .kiv_valid (kiv_valid),
    .kiv_ack   (kiv_ack),
    .err       (err)
  );

  function automatic pair_t model(input frame_t f);
    pair_t p;
    logic [191:0] kf;
    kf = '0;
    p.iv = {f[0], f[1], f[2], f[3]};
    for (int i = 4; i < 28; i++) kf = {kf[183:0], f[i]};
    p.key = kf[188:0];
    return p;
  endfunction

  task automatic rand_frame(output frame_t f);
    for (int i = 0; i < 28; i++) f[i] = 8'($urandom);
    f[4] = f[4] & 8'h1F;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input frame_t f, input int n,
                      input int s1, input int s2);
    for (int i = 0; i < n; i++) begin
      din       = f[i];
      din_valid = 1'b1;
      start     = (i == s1) || (i == s2);
      tick();
    end
    din_valid = 1'b0;
    start     = 1'b0;
    din       = 8'h00;
  endtask

  task automatic full_frame(input frame_t f,
                            input int s1 = -1, input int s2 = -1);
    sb.push_back(model(f));
    pulse_start();
    send(f, 28, s1, s2);
    tick();
  endtask

  task automatic do_ack();
    kiv_ack = 1'b1;
    tick();
    kiv_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; din = 8'h00;
    din_valid = 1'b0; kiv_ack = 1'b0;
    #12;
    n_checks++;
    if (key_o !== '0) begin
      n_fail++; $display("FAIL reset_key got %h exp 0", key_o);
    end
    n_checks++;
    if (iv_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_iv got %h exp 0", iv_o);
    end
    n_checks++;
    if (kiv_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got %b exp 0", kiv_valid);
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL reset_err got %b exp 0", err);
    end
    n_checks++;
    if (din_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready got %b exp 0", din_ready);
    end
    @(negedge clk) reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    frame_t f;
    pair_t e;
    for (int i = 0; i < 28; i++) f[i] = 8'hAA;
    f[0] = 8'hC3; f[1] = 8'h3C; f[2] = 8'hB3; f[3] = 8'h32;
    f[4] = 8'h1F;
    full_frame(f);
    e = sb.pop_front();
    n_checks++;
    if (iv_o !== 32'hC33CB332) begin
      n_fail++; $display("FAIL basic_iv got %h exp c33cb332", iv_o);
    end
    n_checks++;
    if (key_o[188:184] !== 5'h1F) begin
      n_fail++; $display("FAIL basic_keytop got %h exp 1f", key_o[188:184]);
    end
    n_checks++;
    if (key_o[183:0] !== {23{8'hAA}}) begin
      n_fail++; $display("FAIL basic_keyaa got %h", key_o[183:0]);
    end
    n_checks++;
    if (key_o !== e.key) begin
      n_fail++; $display("FAIL basic_sb_key got %h exp %h", key_o, e.key);
    end
    n_checks++;
    if (kiv_valid !== 1'b1 || err !== 1'b0) begin
      n_fail++; $display("FAIL basic_flags got v=%b e=%b exp v=1 e=0",
                         kiv_valid, err);
    end
    do_ack();
    n_checks++;
    if (kiv_valid !== 1'b0) begin
      n_fail++; $display("FAIL ack_clear got %b exp 0", kiv_valid);
    end
    n_checks++;
    if (key_o !== e.key || iv_o !== e.iv) begin
      n_fail++; $display("FAIL ack_hold_data got %h/%h", key_o, iv_o);
    end
    do_ack();
    tick();
    n_checks++;
    if (kiv_valid !== 1'b0 || iv_o !== e.iv) begin
      n_fail++; $display("FAIL idle_ack got v=%b iv=%h exp v=0 iv=%h",
                         kiv_valid, iv_o, e.iv);
    end
  endtask

  task automatic test_pad();
    frame_t f;
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    tick();
    for (int i = 0; i < 28; i++) f[i] = 8'hAA;
    f[0] = 8'hC3; f[1] = 8'h3C; f[2] = 8'hB3; f[3] = 8'h32;
    f[4] = 8'h3F;
    pulse_start();
    send(f, 5, -1, -1);
    n_checks++;
    if (err !== 1'b1 || din_ready !== 1'b0) begin
      n_fail++; $display("FAIL pad_abort got e=%b r=%b exp e=1 r=0",
                         err, din_ready);
    end
    din = f[5]; din_valid = 1'b1;
    tick(); tick(); tick();
    din_valid = 1'b0;
    n_checks++;
    if (err !== 1'b1 || kiv_valid !== 1'b0 || din_ready !== 1'b0) begin
      n_fail++; $display("FAIL pad_after got e=%b v=%b r=%b exp 1 0 0",
                         err, kiv_valid, din_ready);
    end
    n_checks++;
    if (key_o !== '0 || iv_o !== 32'h0) begin
      n_fail++; $display("FAIL pad_data got %h/%h exp 0", key_o, iv_o);
    end
  endtask

  task automatic test_timeout();
    frame_t f;
    frame_t f2;
    pair_t e;
    rand_frame(f);
    rand_frame(f2);
    pulse_start();
    send(f, 11, -1, -1);
    tick(); tick(); tick();
    n_checks++;
    if (din_ready !== 1'b1 || err !== 1'b0) begin
      n_fail++; $display("FAIL tmo_early got r=%b e=%b exp r=1 e=0",
                         din_ready, err);
    end
    tick();
    n_checks++;
    if (err !== 1'b1 || din_ready !== 1'b0) begin
      n_fail++; $display("FAIL tmo_abort got e=%b r=%b exp e=1 r=0",
                         err, din_ready);
    end
    tick();
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL tmo_sticky got %b exp 1", err);
    end
    sb.push_back(model(f2));
    pulse_start();
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL tmo_errclr got %b exp 0", err);
    end
    send(f2, 28, -1, -1);
    tick();
    e = sb.pop_front();
    n_checks++;
    if (key_o !== e.key || iv_o !== e.iv || kiv_valid !== 1'b1) begin
      n_fail++; $display("FAIL tmo_recover got %h/%h v=%b exp %h/%h v=1",
                         key_o, iv_o, kiv_valid, e.key, e.iv);
    end
    do_ack();
  endtask

  task automatic test_reset_mid();
    frame_t f;
    pair_t e;
    rand_frame(f);
    pulse_start();
    send(f, 16, -1, -1);
    @(negedge clk) reset = 1'b0;
    #1;
    n_checks++;
    if (key_o !== '0 || iv_o !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid_data got %h/%h exp 0", key_o, iv_o);
    end
    n_checks++;
    if (kiv_valid !== 1'b0 || err !== 1'b0 || din_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_flags got v=%b e=%b r=%b exp 0",
                         kiv_valid, err, din_ready);
    end
    @(negedge clk) reset = 1'b1;
    din = f[0]; din_valid = 1'b1;
    tick(); tick();
    n_checks++;
    if (din_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_nostart got %b exp 0", din_ready);
    end
    din_valid = 1'b0;
    rand_frame(f);
    full_frame(f);
    e = sb.pop_front();
    n_checks++;
    if (key_o !== e.key || iv_o !== e.iv || kiv_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_recover got %h/%h v=%b exp %h/%h v=1",
                         key_o, iv_o, kiv_valid, e.key, e.iv);
    end
    do_ack();
  endtask

  task automatic test_back_to_back();
    frame_t fa;
    frame_t fb;
    pair_t e;
    rand_frame(fa);
    rand_frame(fb);
    full_frame(fa);
    e = sb.pop_front();
    n_checks++;
    if (key_o !== e.key || kiv_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first got %h v=%b exp %h v=1",
                         key_o, kiv_valid, e.key);
    end
    kiv_ack = 1'b1;
    full_frame(fb);
    e = sb.pop_front();
    n_checks++;
    if (kiv_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_winner got %b exp 1", kiv_valid);
    end
    n_checks++;
    if (key_o !== e.key || iv_o !== e.iv) begin
      n_fail++; $display("FAIL b2b_second got %h/%h exp %h/%h",
                         key_o, iv_o, e.key, e.iv);
    end
    tick();
    kiv_ack = 1'b0;
    n_checks++;
    if (kiv_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_ackclr got %b exp 0", kiv_valid);
    end
  endtask

  task automatic test_start_ignore();
    frame_t f;
    pair_t e;
    rand_frame(f);
    full_frame(f, 5, 20);
    e = sb.pop_front();
    n_checks++;
    if (key_o !== e.key || iv_o !== e.iv || kiv_valid !== 1'b1) begin
      n_fail++; $display("FAIL start_ign got %h/%h v=%b exp %h/%h v=1",
                         key_o, iv_o, kiv_valid, e.key, e.iv);
    end
    do_ack();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_pad();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_start_ignore();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL sb_drain got %0d left exp 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
